// File: rtl/hmc_pwr_seq_ctrl.sv
// hmc_pwr_seq_ctrl: HMC power-up, reset and sleep sequencer driving P_RST_N/LXRXPS and monitoring LXTXPS/FERR_N
module hmc_pwr_seq_ctrl #(
  parameter int RST_HOLD_CYCLES  = 64,
  parameter int INIT_WAIT_CYCLES = 256,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       cfg_start,
  input  logic       cfg_sleep_req,
  input  logic       cfg_err_clr,
  output logic       P_RST_N,
  output logic       LXRXPS,
  input  logic       LXTXPS,
  input  logic       FERR_N,
  output logic [2:0] state,
  output logic       link_ready,
  output logic       timeout_err,
  output logic       fatal_err
);
  typedef enum logic [2:0] {IDLE, RST, INIT, WAIT_TX, ACTIVE, SLEEP_ENT, SLEEP, FAULT} state_t;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic lxtxps_m, lxtxps_s, ferr_n_m, ferr_n_s;
  logic ferr_hit, abort, tmo_hit;
  assign state    = cur;
  assign ferr_hit = !ferr_n_s && (cur inside {INIT, WAIT_TX, ACTIVE, SLEEP_ENT, SLEEP});
  assign abort    = !cfg_start && (cur inside {RST, INIT, WAIT_TX, ACTIVE, SLEEP_ENT, SLEEP});
  assign tmo_hit  = !ferr_hit && !abort && nxt == FAULT && cur != FAULT;
  // two-flop synchronisers for the asynchronous HMC sideband inputs
  always_ff @(posedge clk) begin
    if (!res_n) begin
      lxtxps_m <= 1'b0;
      lxtxps_s <= 1'b0;
      ferr_n_m <= 1'b1;
      ferr_n_s <= 1'b1;
    end else begin
      lxtxps_m <= LXTXPS;
      lxtxps_s <= lxtxps_m;
      ferr_n_m <= FERR_N;
      ferr_n_s <= ferr_n_m;
    end
  end
  // next state; later assignments override earlier ones so FERR beats abort beats the per-state moves
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:      nxt = cfg_start ? RST : IDLE;
      RST:       nxt = cnt == RST_LAST ? INIT : RST;
      INIT:      nxt = cnt == INIT_LAST ? WAIT_TX : INIT;
      WAIT_TX:   nxt = lxtxps_s ? ACTIVE : cnt == TMO_LAST ? FAULT : WAIT_TX;
      ACTIVE:    nxt = cfg_sleep_req ? SLEEP_ENT : ACTIVE;
      SLEEP_ENT: nxt = !lxtxps_s ? SLEEP : cnt == TMO_LAST ? FAULT : SLEEP_ENT;
      SLEEP:     nxt = cfg_sleep_req ? SLEEP : WAIT_TX;
      FAULT:     nxt = cfg_err_clr ? IDLE : FAULT;
    endcase
    if (abort) nxt = IDLE;
    if (ferr_hit) nxt = FAULT;
  end
  // state, dwell counter and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cur         <= IDLE;
      cnt         <= '0;
      P_RST_N     <= 1'b0;
      LXRXPS      <= 1'b0;
      link_ready  <= 1'b0;
      timeout_err <= 1'b0;
      fatal_err   <= 1'b0;
    end else begin
      cur         <= nxt;
      cnt         <= nxt != cur ? '0 : &cnt ? cnt : cnt + 1'b1;
      P_RST_N     <= !(nxt inside {IDLE, RST, FAULT});
      LXRXPS      <= nxt inside {WAIT_TX, ACTIVE};
      link_ready  <= nxt == ACTIVE && lxtxps_s;
      timeout_err <= (cur == FAULT && cfg_err_clr) ? 1'b0 : timeout_err | tmo_hit;
      fatal_err   <= (cur == FAULT && cfg_err_clr) ? 1'b0 : fatal_err | ferr_hit;
    end
  end
endmodule

// File: tb/tb_hmc_pwr_seq_ctrl.sv
// tb_hmc_pwr_seq_ctrl: directed self-checking bench for the HMC power sequencer
module tb_hmc_pwr_seq_ctrl;
  localparam logic [31:0] S_IDLE = 0, S_RST = 1, S_INIT = 2, S_WAIT = 3, S_ACT = 4, S_SENT = 5, S_SLP = 6, S_FLT = 7;
  logic clk = 1'b0;
  logic res_n, cfg_start, cfg_sleep_req, cfg_err_clr, LXTXPS, FERR_N;
  logic P_RST_N, LXRXPS, link_ready, timeout_err, fatal_err;
  logic [2:0] state;
  int tests = 0;
  int fails = 0;
  hmc_pwr_seq_ctrl dut (
    .clk(clk), .res_n(res_n), .cfg_start(cfg_start), .cfg_sleep_req(cfg_sleep_req),
    .cfg_err_clr(cfg_err_clr), .P_RST_N(P_RST_N), .LXRXPS(LXRXPS), .LXTXPS(LXTXPS),
    .FERR_N(FERR_N), .state(state), .link_ready(link_ready), .timeout_err(timeout_err),
    .fatal_err(fatal_err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), S_IDLE);
    chk({tag, "_prst"}, 32'(P_RST_N), 0);
    chk({tag, "_lxrx"}, 32'(LXRXPS), 0);
    chk({tag, "_ready"}, 32'(link_ready), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
    chk({tag, "_fat"}, 32'(fatal_err), 0);
  endtask
  initial begin
    res_n = 0; cfg_start = 0; cfg_sleep_req = 0; cfg_err_clr = 0; LXTXPS = 0; FERR_N = 1;
    tick(2);
    chk_reset("rst");
    res_n = 1;
    tick(1);
    chk("idle_hold", 32'(state), S_IDLE);
    LXTXPS = 1;
    tick(3);
    cfg_start = 1;
    tick(64);
    chk("pu64_prst", 32'(P_RST_N), 0);
    chk("pu64_state", 32'(state), S_RST);
    tick(1);
    chk("pu65_prst", 32'(P_RST_N), 1);
    chk("pu65_state", 32'(state), S_INIT);
    tick(255);
    chk("pu320_lxrx", 32'(LXRXPS), 0);
    tick(1);
    chk("pu321_lxrx", 32'(LXRXPS), 1);
    tick(2);
    chk("pu323_state", 32'(state), S_ACT);
    chk("pu323_ready", 32'(link_ready), 1);
    cfg_err_clr = 1;
    tick(1);
    cfg_err_clr = 0;
    chk("clr_outside_fault", 32'(state), S_ACT);
    cfg_sleep_req = 1;
    tick(1);
    chk("slp_ent_state", 32'(state), S_SENT);
    chk("slp_ent_lxrx", 32'(LXRXPS), 0);
    chk("slp_ent_prst", 32'(P_RST_N), 1);
    chk("slp_ent_ready", 32'(link_ready), 0);
    tick(10);
    chk("slp_ent_wait", 32'(state), S_SENT);
    LXTXPS = 0;
    tick(2);
    chk("slp_ent_sync", 32'(state), S_SENT);
    tick(1);
    chk("slp_state", 32'(state), S_SLP);
    cfg_sleep_req = 0;
    tick(1);
    chk("wake_state", 32'(state), S_WAIT);
    chk("wake_lxrx", 32'(LXRXPS), 1);
    LXTXPS = 1;
    tick(2);
    chk("wake_sync", 32'(state), S_WAIT);
    tick(1);
    chk("wake_active", 32'(state), S_ACT);
    chk("wake_ready", 32'(link_ready), 1);
    LXTXPS = 0;
    tick(2);
    chk("drop_ready_pre", 32'(link_ready), 1);
    tick(1);
    chk("drop_state", 32'(state), S_ACT);
    chk("drop_ready", 32'(link_ready), 0);
    LXTXPS = 1;
    tick(3);
    chk("rise_ready", 32'(link_ready), 1);
    FERR_N = 0;
    tick(2);
    chk("ferr_sync", 32'(state), S_ACT);
    tick(1);
    chk("ferr_state", 32'(state), S_FLT);
    chk("ferr_fat", 32'(fatal_err), 1);
    chk("ferr_prst", 32'(P_RST_N), 0);
    chk("ferr_lxrx", 32'(LXRXPS), 0);
    chk("ferr_ready", 32'(link_ready), 0);
    FERR_N = 1;
    tick(3);
    chk("ferr_sticky", 32'(fatal_err), 1);
    chk("ferr_hold", 32'(state), S_FLT);
    cfg_start = 0;
    tick(1);
    chk("fault_ign_start", 32'(state), S_FLT);
    cfg_err_clr = 1;
    tick(1);
    cfg_err_clr = 0;
    chk("fclr_state", 32'(state), S_IDLE);
    chk("fclr_fat", 32'(fatal_err), 0);
    cfg_start = 1;
    tick(1);
    chk("rst_enter", 32'(state), S_RST);
    FERR_N = 0;
    tick(5);
    chk("rst_ferr_state", 32'(state), S_RST);
    chk("rst_ferr_fat", 32'(fatal_err), 0);
    FERR_N = 1;
    tick(59);
    chk("abort_init", 32'(state), S_INIT);
    cfg_start = 0;
    tick(1);
    chk("abort_state", 32'(state), S_IDLE);
    chk("abort_prst", 32'(P_RST_N), 0);
    LXTXPS = 0;
    tick(3);
    cfg_start = 1;
    tick(321);
    chk("tmo_wait", 32'(state), S_WAIT);
    tick(1023);
    chk("tmo_last", 32'(state), S_WAIT);
    chk("tmo_last_flag", 32'(timeout_err), 0);
    tick(1);
    chk("tmo_state", 32'(state), S_FLT);
    chk("tmo_flag", 32'(timeout_err), 1);
    chk("tmo_prst", 32'(P_RST_N), 0);
    chk("tmo_lxrx", 32'(LXRXPS), 0);
    chk("tmo_fat", 32'(fatal_err), 0);
    cfg_err_clr = 1;
    tick(1);
    cfg_err_clr = 0;
    chk("tclr_state", 32'(state), S_IDLE);
    chk("tclr_flag", 32'(timeout_err), 0);
    LXTXPS = 1;
    tick(322);
    chk("mid_active", 32'(state), S_ACT);
    res_n = 0;
    tick(1);
    res_n = 1;
    chk_reset("mid");
    tick(65);
    chk("prio_init", 32'(state), S_INIT);
    FERR_N = 0;
    tick(2);
    chk("prio_sync", 32'(state), S_INIT);
    cfg_start = 0;
    tick(1);
    chk("prio_state", 32'(state), S_FLT);
    chk("prio_fat", 32'(fatal_err), 1);
    FERR_N = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
